// File: rtl/wb_gain_pkg.sv
// Shared constants and helpers for the multi-channel white-balance gain core.
// Pixel and gain widths are module parameters, so px_t/gain_t live there.
package wb_gain_pkg;

  localparam int WB_GAIN_LATENCY = 3;

  function automatic int UNITY_GAIN(input int fract_width);
    return 1 << fract_width;
  endfunction

  function automatic int tdata_width(input int px, input int ch);
    return ((px * ch + 7) / 8) * 8;
  endfunction

endpackage

// File: rtl/wb_gain_mult_sat.sv
// One channel of the S2 multiply and S3 round/saturate datapath.
// Both stages share the global advance enable.
module wb_gain_mult_sat
  import wb_gain_pkg::*;
#(
  parameter int PX_WIDTH    = 10,
  parameter int GAIN_WIDTH  = 16,
  parameter int FRACT_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  i_adv,
  input  logic [PX_WIDTH-1:0]   i_px,
  input  logic [GAIN_WIDTH-1:0] i_gain,
  input  logic                  i_bypass,
  output logic [PX_WIDTH-1:0]   o_px
);

  localparam int LP_PW = PX_WIDTH + GAIN_WIDTH;
  localparam logic [LP_PW:0] LP_HALF =
    (LP_PW + 1)'(1) << (FRACT_WIDTH - 1);
  localparam logic [LP_PW:0] LP_MAX =
    {{(LP_PW + 1 - PX_WIDTH){1'b0}}, {PX_WIDTH{1'b1}}};

  logic [LP_PW-1:0]    r_prod;
  logic [PX_WIDTH-1:0] r_px;
  logic                r_byp;
  logic [PX_WIDTH-1:0] r_out;
  logic [LP_PW:0]      w_sum;
  logic [LP_PW:0]      w_shift;
  logic [PX_WIDTH-1:0] w_sat;

  // Extra MSB keeps the rounding add from overflowing.
  assign w_sum   = {1'b0, r_prod} + LP_HALF;
  assign w_shift = w_sum >> FRACT_WIDTH;
  assign w_sat   = (w_shift > LP_MAX) ? {PX_WIDTH{1'b1}}
                                      : w_shift[PX_WIDTH-1:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_prod <= '0;
      r_px   <= '0;
      r_byp  <= 1'b0;
      r_out  <= '0;
    end else if (i_adv) begin
      r_prod <= LP_PW'(i_px) * LP_PW'(i_gain);
      r_px   <= i_px;
      r_byp  <= i_bypass;
      r_out  <= r_byp ? r_px : w_sat;
    end
  end

  assign o_px = r_out;

endmodule

// File: rtl/multi_ch_gain_corrector.sv
// Multi-channel AXI4-Stream gain corrector with frame-synchronous
// double-buffered gains, rounding, saturation and full backpressure.
module multi_ch_gain_corrector
  import wb_gain_pkg::*;
#(
  parameter int PX_WIDTH    = 10,
  parameter int CH_NUM      = 3,
  parameter int GAIN_WIDTH  = 16,
  parameter int FRACT_WIDTH = 10,
  parameter int TDATA_WIDTH = tdata_width(PX_WIDTH, CH_NUM)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         video_i_tvalid,
  input  logic [TDATA_WIDTH-1:0]       video_i_tdata,
  input  logic                         video_i_tlast,
  input  logic                         video_i_tuser,
  output logic                         video_i_tready,
  output logic                         video_o_tvalid,
  output logic [TDATA_WIDTH-1:0]       video_o_tdata,
  output logic                         video_o_tlast,
  output logic                         video_o_tuser,
  input  logic                         video_o_tready,
  input  logic                         coef_wr_i,
  input  logic [CH_NUM*GAIN_WIDTH-1:0] coef_i,
  input  logic                         bypass_i,
  output logic                         coef_pending_o,
  output logic [15:0]                  frame_cnt_o
);

  localparam int LP_DW = PX_WIDTH * CH_NUM;
  localparam int LP_GW = GAIN_WIDTH * CH_NUM;
  localparam logic [GAIN_WIDTH-1:0] LP_UNITY =
    GAIN_WIDTH'(UNITY_GAIN(FRACT_WIDTH));

  logic             w_adv;
  logic             w_acc;
  logic             w_sof_acc;
  logic             w_activate;
  logic [LP_GW-1:0] w_gain_sel;
  logic             w_byp_sel;
  logic [LP_DW-1:0] w_out_px;
  logic             w_unused_pad;

  logic [LP_GW-1:0] r_shadow_gain;
  logic [LP_GW-1:0] r_active_gain;
  logic             r_shadow_byp;
  logic             r_active_byp;
  logic             r_pending;
  logic [15:0]      r_frame_cnt;

  logic             r_s1_valid;
  logic             r_s1_last;
  logic             r_s1_user;
  logic [LP_DW-1:0] r_s1_px;
  logic [LP_GW-1:0] r_s1_gain;
  logic             r_s1_byp;
  logic             r_s2_valid;
  logic             r_s2_last;
  logic             r_s2_user;
  logic             r_s3_valid;
  logic             r_s3_last;
  logic             r_s3_user;

  assign w_adv      = !r_s3_valid || video_o_tready;
  assign w_acc      = video_i_tvalid && w_adv;
  assign w_sof_acc  = w_acc && video_i_tuser;
  assign w_activate = w_sof_acc && r_pending;

  // The activating SOF beat already picks up the shadow values.
  assign w_gain_sel = w_activate ? r_shadow_gain : r_active_gain;
  assign w_byp_sel  = w_activate ? r_shadow_byp : r_active_byp;

  assign w_unused_pad = ^video_i_tdata;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_shadow_gain <= {CH_NUM{LP_UNITY}};
      r_active_gain <= {CH_NUM{LP_UNITY}};
      r_shadow_byp  <= 1'b0;
      r_active_byp  <= 1'b0;
      r_pending     <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      if (w_activate) begin
        r_active_gain <= r_shadow_gain;
        r_active_byp  <= r_shadow_byp;
      end
      if (coef_wr_i) begin
        r_shadow_gain <= coef_i;
        r_shadow_byp  <= bypass_i;
        r_pending     <= 1'b1;
      end else if (w_activate) begin
        r_pending <= 1'b0;
      end
      if (w_sof_acc) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_user  <= 1'b0;
      r_s1_px    <= '0;
      r_s1_gain  <= '0;
      r_s1_byp   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_user  <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
      r_s3_user  <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= video_i_tvalid;
      r_s1_last  <= video_i_tlast;
      r_s1_user  <= video_i_tuser;
      r_s1_px    <= video_i_tdata[LP_DW-1:0];
      r_s1_gain  <= w_gain_sel;
      r_s1_byp   <= w_byp_sel;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_user  <= r_s1_user;
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_last;
      r_s3_user  <= r_s2_user;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    wb_gain_mult_sat #(
      .PX_WIDTH   (PX_WIDTH),
      .GAIN_WIDTH (GAIN_WIDTH),
      .FRACT_WIDTH(FRACT_WIDTH)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .i_adv   (w_adv),
      .i_px    (r_s1_px[k*PX_WIDTH +: PX_WIDTH]),
      .i_gain  (r_s1_gain[k*GAIN_WIDTH +: GAIN_WIDTH]),
      .i_bypass(r_s1_byp),
      .o_px    (w_out_px[k*PX_WIDTH +: PX_WIDTH])
    );
  end

  assign video_i_tready = w_adv;
  assign video_o_tvalid = r_s3_valid;
  assign video_o_tdata  = TDATA_WIDTH'(w_out_px);
  assign video_o_tlast  = r_s3_last;
  assign video_o_tuser  = r_s3_user;
  assign coef_pending_o = r_pending;
  assign frame_cnt_o    = r_frame_cnt;

endmodule

// File: tb/tb_multi_ch_gain_corrector.sv
// Scoreboard bench for multi_ch_gain_corrector (10-bit, 3 channels,
// Q6.10 gains).
module tb_multi_ch_gain_corrector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        video_i_tvalid;
  logic [31:0] video_i_tdata;
  logic        video_i_tlast;
  logic        video_i_tuser;
  logic        video_i_tready;
  logic        video_o_tvalid;
  logic [31:0] video_o_tdata;
  logic        video_o_tlast;
  logic        video_o_tuser;
  logic        video_o_tready = 1'b1;
  logic        coef_wr_i;
  logic [47:0] coef_i;
  logic        bypass_i;
  logic        coef_pending_o;
  logic [15:0] frame_cnt_o;

  always #5 clk = ~clk;

  multi_ch_gain_corrector #(
    .PX_WIDTH   (10),
    .CH_NUM     (3),
    .GAIN_WIDTH (16),
    .FRACT_WIDTH(10)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .video_i_tvalid(video_i_tvalid),
    .video_i_tdata (video_i_tdata),
    .video_i_tlast (video_i_tlast),
    .video_i_tuser (video_i_tuser),
    .video_i_tready(video_i_tready),
    .video_o_tvalid(video_o_tvalid),
    .video_o_tdata (video_o_tdata),
    .video_o_tlast (video_o_tlast),
    .video_o_tuser (video_o_tuser),
    .video_o_tready(video_o_tready),
    .coef_wr_i     (coef_wr_i),
    .coef_i        (coef_i),
    .bypass_i      (bypass_i),
    .coef_pending_o(coef_pending_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  logic [33:0] q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_frames = '0;
  logic        rnd_rdy = 1'b0;
  logic        hold_pend = 1'b0;
  logic [33:0] hold_val;
  logic [33:0] obs;
  logic [33:0] exp_beat;

  function automatic logic [33:0] pack(input logic l, input logic u,
    input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    return {l, u, 2'b00, c, b, a};
  endfunction

  function automatic logic [9:0] mdl(input logic [9:0] p,
                                     input logic [15:0] g);
    logic [31:0] t;
    t = 32'(p) * 32'(g) + 32'd512;
    t = t >> 10;
    return (t > 32'd1023) ? 10'd1023 : t[9:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) begin
    #1 video_o_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    obs = {video_o_tlast, video_o_tuser, video_o_tdata};
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        n_vec++;
        if (obs !== hold_val) begin
          n_err++;
          $display("FAIL hold: got %h, want %h", obs, hold_val);
        end
      end
      if (video_o_tvalid && video_o_tready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got %h, want none", obs);
        end else begin
          exp_beat = q.pop_front();
          if (obs !== exp_beat) begin
            n_err++;
            $display("FAIL beat: got %h, want %h", obs, exp_beat);
          end
        end
      end
      hold_pend = video_o_tvalid && !video_o_tready;
      hold_val  = obs;
    end
  end

  task automatic wr_coef(input logic [15:0] g0, input logic [15:0] g1,
                         input logic [15:0] g2, input logic byp);
    coef_i    = {g2, g1, g0};
    bypass_i  = byp;
    coef_wr_i = 1'b1;
    step(1);
    coef_wr_i = 1'b0;
  endtask

  task automatic send(input logic [9:0] p0, input logic [9:0] p1,
    input logic [9:0] p2, input logic l, input logic u,
    input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2,
    input logic wr);
    logic acc;
    int   t;
    acc            = 1'b0;
    t              = 0;
    video_i_tvalid = 1'b1;
    video_i_tdata  = {2'b00, p2, p1, p0};
    video_i_tlast  = l;
    video_i_tuser  = u;
    coef_wr_i      = wr;
    while (!acc && t < 1000) begin
      @(negedge clk);
      acc = video_i_tready;
      @(posedge clk);
      #1;
      t++;
    end
    video_i_tvalid = 1'b0;
    video_i_tlast  = 1'b0;
    video_i_tuser  = 1'b0;
    coef_wr_i      = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no tready, want tready");
    end else begin
      q.push_back(pack(l, u, e0, e1, e2));
      if (u) exp_frames++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 3000) begin
      step(1);
      t++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending beats, want 0", q.size());
    end
  endtask

  initial begin
    logic [15:0] g0, g1, g2;
    logic [9:0]  a, b, c;
    rst_n          = 1'b0;
    video_i_tvalid = 1'b0;
    video_i_tdata  = '0;
    video_i_tlast  = 1'b0;
    video_i_tuser  = 1'b0;
    coef_wr_i      = 1'b0;
    coef_i         = '0;
    bypass_i       = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_tvalid", video_o_tvalid, 0);
    chk("rst_tdata", video_o_tdata, 0);
    chk("rst_side", {video_o_tlast, video_o_tuser}, 0);
    chk("rst_pending", coef_pending_o, 0);
    chk("rst_frames", frame_cnt_o, 0);
    step(1);
    rst_n = 1'b1;
    step(1);

    send(100, 200, 300, 0, 1, 100, 200, 300, 0);
    @(negedge clk);
    @(negedge clk);
    chk("lat_early", video_o_tvalid, 0);
    @(negedge clk);
    chk("lat_3", video_o_tvalid, 1);
    chk("pending_idle", coef_pending_o, 0);
    chk("frames_1", frame_cnt_o, exp_frames);
    step(1);

    wr_coef(16'h800, 16'h400, 16'h200, 0);
    @(negedge clk);
    chk("pending_set", coef_pending_o, 1);
    step(1);
    send(600, 300, 3, 0, 1, 1023, 300, 2, 0);
    @(negedge clk);
    chk("pending_clr", coef_pending_o, 0);
    step(1);
    send(10, 11, 13, 1, 0, 20, 11, 7, 0);

    send(50, 50, 50, 0, 1, 100, 50, 25, 0);
    wr_coef(16'h400, 16'h400, 16'h400, 0);
    send(50, 50, 50, 1, 0, 100, 50, 25, 0);
    @(negedge clk);
    chk("pending_mid", coef_pending_o, 1);
    step(1);
    send(50, 50, 50, 0, 1, 50, 50, 50, 0);
    @(negedge clk);
    chk("pending_next_sof", coef_pending_o, 0);
    chk("frames_mid", frame_cnt_o, exp_frames);
    step(1);

    coef_i   = {3{16'h200}};
    bypass_i = 1'b0;
    send(100, 100, 100, 0, 1, 100, 100, 100, 1);
    @(negedge clk);
    chk("pending_simul", coef_pending_o, 1);
    step(1);
    send(100, 100, 100, 1, 0, 100, 100, 100, 0);
    send(100, 100, 100, 0, 1, 50, 50, 50, 0);
    @(negedge clk);
    chk("pending_simul_clr", coef_pending_o, 0);
    step(1);
    wr_coef(16'h800, 16'h800, 16'h800, 0);
    coef_i = {3{16'h400}};
    send(100, 100, 100, 0, 1, 200, 200, 200, 1);
    @(negedge clk);
    chk("pending_overlap", coef_pending_o, 1);
    step(1);
    send(100, 100, 100, 0, 1, 100, 100, 100, 0);
    @(negedge clk);
    chk("pending_overlap_clr", coef_pending_o, 0);
    step(1);

    while (exp_frames != 16'hFFFF) send(1, 2, 3, 0, 1, 1, 2, 3, 0);
    @(negedge clk);
    chk("frames_ffff", frame_cnt_o, 16'hFFFF);
    step(1);
    send(1, 2, 3, 0, 1, 1, 2, 3, 0);
    @(negedge clk);
    chk("frames_wrap", frame_cnt_o, 16'h0000);
    step(1);
    drain();

    rnd_rdy = 1'b1;
    g0 = 16'h5A3;
    g1 = 16'h1FF;
    g2 = 16'h400;
    wr_coef(g0, g1, g2, 0);
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 64; col++) begin
        step($urandom_range(0, 2));
        a = 10'($urandom_range(0, 1023));
        b = 10'($urandom_range(0, 1023));
        c = 10'($urandom_range(0, 1023));
        send(a, b, c, col == 63, r == 0 && col == 0,
             mdl(a, g0), mdl(b, g1), mdl(c, g2), 0);
      end
    end
    drain();
    rnd_rdy = 1'b0;
    step(2);

    wr_coef(16'h0, 16'h0, 16'h0, 1);
    send(1, 512, 1023, 0, 1, 1, 512, 1023, 0);
    wr_coef(16'h123, 16'h123, 16'h123, 0);
    send(5, 6, 7, 0, 0, 5, 6, 7, 0);
    send(8, 9, 10, 0, 0, 8, 9, 10, 0);
    send(11, 12, 13, 1, 0, 11, 12, 13, 0);
    chk("pre_rst_valid", video_o_tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", video_o_tvalid, 0);
    chk("midrst_tdata", video_o_tdata, 0);
    chk("midrst_pending", coef_pending_o, 0);
    chk("midrst_frames", frame_cnt_o, 0);
    q.delete();
    exp_frames = '0;
    step(3);
    rst_n = 1'b1;
    step(6);
    chk("no_replay", video_o_tvalid, 0);
    send(100, 200, 300, 0, 1, 100, 200, 300, 0);
    drain();
    chk("frames_after_rst", frame_cnt_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
